// File: rtl/dbus_timer_pkg.sv
// dbus_timer_pkg: shared constants and types for the dbus interval timer.
//   - register offsets within the 8-byte window
//   - bit indices for CTRL, STATUS and CMD
//   - reset values for every architectural register
package dbus_timer_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_PERIOD_L = 3'd2;
    localparam logic [2:0] OFF_PERIOD_H = 3'd3;
    localparam logic [2:0] OFF_SNAP_L   = 3'd4;
    localparam logic [2:0] OFF_SNAP_H   = 3'd5;
    localparam logic [2:0] OFF_STATUS   = 3'd6;
    localparam logic [2:0] OFF_CMD      = 3'd7;

    // CTRL bits
    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;

    // STATUS bits
    localparam int STATUS_EXPIRED = 0;
    localparam int STATUS_RUNNING = 1;

    // CMD bits
    localparam int CMD_RESTART = 0;
    localparam int CMD_SNAP    = 1;

    // CTRL storage; field order puts en at bit 0 so a byte slice casts directly
    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

    // Reset values
    localparam ctrl_t       CTRL_RST     = '0;
    localparam logic [7:0]  PRESCALE_RST = 8'h00;
    localparam logic [15:0] PERIOD_RST   = 16'h0000;
    localparam logic [15:0] COUNT_RST    = 16'h0000;
    localparam logic [15:0] SNAP_RST     = 16'h0000;
    localparam logic        EXPIRED_RST  = 1'b0;
    localparam logic [7:0]  DOUT_RST     = 8'h00;

    // Decode a written CTRL byte; bits 7:3 are not stored
    function automatic ctrl_t ctrl_from_byte(input logic [7:0] b);
        ctrl_t c;
        c.en          = b[CTRL_EN];
        c.auto_reload = b[CTRL_AUTO_RELOAD];
        c.irq_en      = b[CTRL_IRQ_EN];
        return c;
    endfunction

endpackage

// File: rtl/dbus_timer_if.sv
// dbus_timer_if: data-bus signals between the dbus master and a slave.
//   Addr  master->slave  bus address
//   Din   master->slave  write data
//   Wr    master->slave  write strobe (one write per rising edge while high)
//   Dout  slave->master  registered read data
//   Irq   slave->master  registered level interrupt
interface dbus_timer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] Addr;
    logic [DATA_WIDTH-1:0] Din;
    logic                  Wr;
    logic [DATA_WIDTH-1:0] Dout;
    logic                  Irq;

    modport master (output Addr, Din, Wr, input Dout, Irq);
    modport slave  (input Addr, Din, Wr, output Dout, Irq);
endinterface

// File: rtl/dbus_timer_prescaler.sv
// dbus_timer_prescaler: 8-bit clock divider for the timer.
//   Clk, Rst_n  clock, async active-low reset
//   en          count enable; when low the counter holds its value
//   clr         synchronous clear, takes priority over en
//   prescale    terminal value; tick fires once every prescale+1 enabled clocks
//   tick        one-cycle pulse while the counter sits on prescale and en=1
module dbus_timer_prescaler (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] prescale,
    output logic       tick
);
    logic [7:0] cnt;
    logic       hit;

    // If prescale is lowered below cnt, cnt runs on through 255 and wraps
    // to 0 before it can match again.
    assign hit  = (cnt == prescale);
    assign tick = en & hit;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= 8'h00;
        end else if (clr) begin
            cnt <= 8'h00;
        end else if (en) begin
            cnt <= hit ? 8'h00 : cnt + 8'h01;
        end
    end
endmodule

// File: rtl/dbus_timer.sv
// dbus_timer: register-mapped 16-bit interval timer on the dbus.
//   Clk, Rst_n  clock, async active-low reset
//   bus         dbus slave port (Addr, Din, Wr in; Dout, Irq out)
// Eight byte registers at BASE_ADDR..BASE_ADDR+7: CTRL, PRESCALE, PERIOD_L/H,
// SNAP_L/H, STATUS, CMD. COUNT advances on each prescaler tick; when it has
// reached PERIOD the tick sets sticky EXPIRED and either reloads COUNT to 0 or
// stops the timer. Dout is the registered read mux (1-cycle read latency).
module dbus_timer
    import dbus_timer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h10
) (
    input  logic         Clk,
    input  logic         Rst_n,
    dbus_timer_if.slave  bus
);
    // ---------------- address decode ----------------
    logic [ADDR_WIDTH-1:0] off;
    logic                  hit;
    logic [2:0]            reg_sel;
    logic                  wr_sel;
    logic [7:0]            din;

    // Subtracting the base lets one compare cover both ends of the window:
    // addresses below BASE_ADDR wrap to large offsets and fall outside.
    assign off     = bus.Addr - BASE_ADDR;
    assign hit     = (off[ADDR_WIDTH-1:3] == '0);
    assign reg_sel = off[2:0];
    assign wr_sel  = bus.Wr & hit;
    assign din     = bus.Din[7:0];

    logic wr_ctrl, wr_prescale, wr_period_l, wr_period_h, wr_status, wr_cmd;
    assign wr_ctrl     = wr_sel && (reg_sel == OFF_CTRL);
    assign wr_prescale = wr_sel && (reg_sel == OFF_PRESCALE);
    assign wr_period_l = wr_sel && (reg_sel == OFF_PERIOD_L);
    assign wr_period_h = wr_sel && (reg_sel == OFF_PERIOD_H);
    assign wr_status   = wr_sel && (reg_sel == OFF_STATUS);
    assign wr_cmd      = wr_sel && (reg_sel == OFF_CMD);

    logic restart, snap_req, w1c_expired;
    assign restart     = wr_cmd & din[CMD_RESTART];
    assign snap_req    = wr_cmd & din[CMD_SNAP];
    assign w1c_expired = wr_status & din[STATUS_EXPIRED];

    // ---------------- state ----------------
    ctrl_t       ctrl, ctrl_nxt;
    logic [7:0]  prescale;
    logic [15:0] period;
    logic [15:0] count, count_nxt;
    logic [15:0] snap;
    logic        expired;
    logic        tick;
    logic        expire;
    logic        auto_disable;

    dbus_timer_prescaler u_psc (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .en       (ctrl.en),
        .clr      (restart),
        .prescale (prescale),
        .tick     (tick)
    );

    // COUNT update. RESTART outranks a coincident tick, so that tick neither
    // advances COUNT nor expires. The >= compare makes a PERIOD written below
    // COUNT expire on the next tick instead of wrapping through 65535.
    always_comb begin
        expire    = 1'b0;
        count_nxt = count;
        if (restart) begin
            count_nxt = 16'h0000;
        end else if (tick) begin
            if (count >= period) begin
                expire = 1'b1;
                if (ctrl.auto_reload) count_nxt = 16'h0000;
            end else begin
                count_nxt = count + 16'h0001;
            end
        end
    end

    assign auto_disable = expire & ~ctrl.auto_reload;

    // One-shot expiry clears EN after any same-cycle CTRL write is applied,
    // so a coincident write of EN=0 and the auto-disable agree.
    always_comb begin
        ctrl_nxt = ctrl;
        if (wr_ctrl) ctrl_nxt = ctrl_from_byte(din);
        if (auto_disable) ctrl_nxt.en = 1'b0;
    end

    // ---------------- read mux ----------------
    logic [7:0] rbyte;

    always_comb begin
        rbyte = 8'h00;
        if (hit) begin
            case (reg_sel)
                OFF_CTRL:     rbyte = {5'b00000, ctrl};
                OFF_PRESCALE: rbyte = prescale;
                OFF_PERIOD_L: rbyte = period[7:0];
                OFF_PERIOD_H: rbyte = period[15:8];
                OFF_SNAP_L:   rbyte = snap[7:0];
                OFF_SNAP_H:   rbyte = snap[15:8];
                OFF_STATUS: begin
                    rbyte[STATUS_EXPIRED] = expired;
                    rbyte[STATUS_RUNNING] = ctrl.en;
                end
                OFF_CMD:      rbyte = 8'h00;
                default:      rbyte = 8'h00;
            endcase
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ctrl     <= CTRL_RST;
            prescale <= PRESCALE_RST;
            period   <= PERIOD_RST;
            count    <= COUNT_RST;
            snap     <= SNAP_RST;
            expired  <= EXPIRED_RST;
            bus.Dout <= DATA_WIDTH'(DOUT_RST);
            bus.Irq  <= 1'b0;
        end else begin
            ctrl  <= ctrl_nxt;
            count <= count_nxt;
            if (wr_prescale) prescale     <= din;
            if (wr_period_l) period[7:0]  <= din;
            if (wr_period_h) period[15:8] <= din;
            // Captures COUNT as it stood before this edge's tick or restart
            if (snap_req) snap <= count;
            // Set outranks the write-1-to-clear
            if (expire)           expired <= 1'b1;
            else if (w1c_expired) expired <= 1'b0;
            bus.Dout <= DATA_WIDTH'(rbyte);
            bus.Irq  <= expired & ctrl.irq_en;
        end
    end
endmodule

// File: tb/tb_dbus_timer.sv
module tb_dbus_timer;
    localparam logic [7:0] BASE   = 8'h10;
    localparam logic [7:0] A_CTRL = BASE + 8'd0;
    localparam logic [7:0] A_PSC  = BASE + 8'd1;
    localparam logic [7:0] A_PL   = BASE + 8'd2;
    localparam logic [7:0] A_PH   = BASE + 8'd3;
    localparam logic [7:0] A_SL   = BASE + 8'd4;
    localparam logic [7:0] A_SH   = BASE + 8'd5;
    localparam logic [7:0] A_STAT = BASE + 8'd6;
    localparam logic [7:0] A_CMD  = BASE + 8'd7;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    dbus_timer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    dbus_timer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BASE_ADDR(BASE)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] dout;
        logic       irq;
        bit         chk_irq;
    } exp_t;

    exp_t sb[$];
    logic req = 1'b0;
    logic pending = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    // A read issued at one negedge is sampled by the DUT on the next posedge;
    // the monitor checks the registered outputs at the following negedge.
    always @(posedge Clk) pending <= req;

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (pending) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb_underflow: output presented with no expected entry");
            end else begin
                e = sb.pop_front();
                n_vec++;
                if (bus.Dout !== e.dout) begin
                    n_err++;
                    $display("FAIL %s: Dout=%02h required %02h", e.name, bus.Dout, e.dout);
                end
                if (e.chk_irq) begin
                    n_vec++;
                    if (bus.Irq !== e.irq) begin
                        n_err++;
                        $display("FAIL %s_irq: Irq=%b required %b", e.name, bus.Irq, e.irq);
                    end
                end
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        bus.Addr = a; bus.Din = d; bus.Wr = 1'b1; req = 1'b0;
    endtask

    task automatic rdi(input logic [7:0] a, input logic [7:0] d, input bit ci,
                       input logic irq, input string nm);
        exp_t e;
        @(negedge Clk);
        bus.Addr = a; bus.Din = 8'h00; bus.Wr = 1'b0;
        e.name = nm; e.dout = d; e.irq = irq; e.chk_irq = ci;
        sb.push_back(e);
        req = 1'b1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] d, input string nm);
        rdi(a, d, 1'b0, 1'b0, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            bus.Wr = 1'b0; req = 1'b0;
        end
    endtask

    initial begin
        bus.Addr = 8'h00; bus.Din = 8'h00; bus.Wr = 1'b0;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;

        // Reset state: all eight registers read 0, Irq low
        for (int i = 0; i < 8; i++) rdi(BASE + 8'(i), 8'h00, 1'b1, 1'b0, $sformatf("reset_off%0d", i));

        // One-shot: PRESCALE=3, PERIOD=5 -> expiry on the 24th edge after EN
        wr(A_PSC, 8'h03); wr(A_PL, 8'h05); wr(A_PH, 8'h00);
        wr(A_CTRL, 8'h05);                       // edge 0
        idle(22);                                // edges 1..22
        rdi(A_STAT, 8'h02, 1'b1, 1'b0, "os_e23");
        rdi(A_STAT, 8'h02, 1'b1, 1'b0, "os_e24");
        rdi(A_STAT, 8'h01, 1'b1, 1'b1, "os_e25");
        wr(A_STAT, 8'h01);                       // W1C at edge 26
        rdi(A_STAT, 8'h00, 1'b1, 1'b0, "os_w1c");
        wr(A_CMD, 8'h02);
        rd(A_SL, 8'h05, "os_snap_l");
        rd(A_SH, 8'h00, "os_snap_h");
        wr(A_CMD, 8'h01);

        // Auto-reload: PRESCALE=0, PERIOD=0x0102 -> expiry every 259 clocks
        wr(A_PSC, 8'h00); wr(A_PL, 8'h02); wr(A_PH, 8'h01);
        wr(A_CTRL, 8'h03);                       // edge 0
        idle(258);                               // edges 1..258
        rd(A_STAT, 8'h02, "ar_e259");
        rd(A_STAT, 8'h03, "ar_e260");
        wr(A_STAT, 8'h01);                       // edge 261
        wr(A_CMD, 8'h02);                        // edge 262, coincides with a tick
        rd(A_SL, 8'h02, "ar_snap1_l");
        rd(A_SH, 8'h00, "ar_snap1_h");
        idle(35);                                // edges 265..299
        wr(A_CMD, 8'h02);                        // edge 300
        rd(A_SL, 8'h28, "ar_snap2_l");
        rd(A_SH, 8'h00, "ar_snap2_h");
        idle(215);                               // edges 303..517
        rdi(A_STAT, 8'h02, 1'b1, 1'b0, "ar_e518");
        rdi(A_STAT, 8'h03, 1'b1, 1'b0, "ar_e519");
        wr(A_CTRL, 8'h00); wr(A_CMD, 8'h01); wr(A_STAT, 8'h01);

        // PERIOD=0, PRESCALE=0: expires every clock; W1C on an expiring edge loses
        wr(A_PL, 8'h00); wr(A_PH, 8'h00);
        wr(A_CTRL, 8'h07);                       // edge 0
        idle(1);
        wr(A_STAT, 8'h01);                       // edge 2, expiring tick
        rdi(A_STAT, 8'h03, 1'b1, 1'b1, "p0_w1c_collide");
        wr(A_CMD, 8'h02);
        rd(A_SL, 8'h00, "p0_count");
        wr(A_CTRL, 8'h00);
        wr(A_STAT, 8'h01);
        rdi(A_STAT, 8'h00, 1'b1, 1'b0, "p0_stop");

        // PERIOD lowered to 2 while COUNT=0x80: next tick expires, no wrap
        wr(A_PL, 8'hFF); wr(A_PH, 8'h00); wr(A_CMD, 8'h01);
        wr(A_CTRL, 8'h01);                       // edge 0
        idle(128);                               // edges 1..128
        wr(A_PL, 8'h02);                         // edge 129, COUNT=0x80 before it
        rd(A_STAT, 8'h02, "plow_e130");
        rd(A_STAT, 8'h01, "plow_e131");
        wr(A_CMD, 8'h02);
        rd(A_SL, 8'h81, "plow_snap_l");
        rd(A_SH, 8'h00, "plow_snap_h");
        wr(A_STAT, 8'h01);

        // RESTART on an expiring tick: COUNT=0, EXPIRED stays 0, EN stays 1
        wr(A_PL, 8'h03); wr(A_CMD, 8'h01);
        wr(A_CTRL, 8'h01);                       // edge 0
        idle(3);
        wr(A_CMD, 8'h01);                        // edge 4, COUNT=3 expiring
        wr(A_CMD, 8'h02);                        // edge 5, snap COUNT=0
        rd(A_SL, 8'h00, "rs_count");
        rd(A_STAT, 8'h02, "rs_status");
        wr(A_CTRL, 8'h00);                       // edge 8, also auto-disable
        wr(A_STAT, 8'h01);
        rd(A_STAT, 8'h00, "rs_stop");

        // Decode: out-of-window writes ignored, unused CTRL bits read 0
        wr(BASE + 8'd8, 8'hFF);
        wr(BASE - 8'd1, 8'hFF);
        wr(A_CTRL, 8'hF8);
        rd(A_CTRL, 8'h00, "dec_ctrl");
        rd(A_PSC, 8'h00, "dec_psc");
        rd(A_PL, 8'h03, "dec_pl");
        rd(A_PH, 8'h00, "dec_ph");
        rd(BASE + 8'd8, 8'h00, "dec_rd_hi");
        rd(BASE - 8'd1, 8'h00, "dec_rd_lo");
        rd(A_CMD, 8'h00, "dec_cmd");
        rd(A_STAT, 8'h00, "dec_status");

        // Asynchronous reset mid-count with Irq high
        wr(A_PL, 8'h00);
        wr(A_CTRL, 8'h07);                       // edge 0
        idle(1);
        wr(A_PL, 8'h50);                         // edge 2
        idle(8);                                 // edges 3..10
        rdi(A_STAT, 8'h03, 1'b1, 1'b1, "rst_pre");
        rdi(A_STAT, 8'h00, 1'b1, 1'b0, "rst_async");  // edge 12
        @(posedge Clk); #2 Rst_n = 1'b0;         // lands before the checking negedge
        idle(2);
        @(negedge Clk);
        Rst_n = 1'b1; bus.Wr = 1'b0; req = 1'b0;
        wr(A_CMD, 8'h02);
        rdi(A_SL, 8'h00, 1'b1, 1'b0, "rst_count");
        rd(A_CTRL, 8'h00, "rst_ctrl");
        rd(A_PL, 8'h00, "rst_pl");
        rd(A_STAT, 8'h00, "rst_status");
        idle(3);

        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
